ula_seq: RTL and testbench

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_seq.sv | 101 ++++++++++
 tb/tb_ula_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: sequences commands onto an external combinational ALU and multiplies by repeated addition
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op,a,b   command handshake; accepted only in IDLE
//   ula_code, ula_ah, ula_bb          control word and operands presented to the ALU
//   ula_out                           combinational ALU result
//   res_valid/res_ready, res_data,err result handshake; result held until accepted
module ula_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [5:0]  ula_code,
  output logic [31:0] ula_ah,
  output logic [31:0] ula_bb,
  input  logic [31:0] ula_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3;
  localparam logic [5:0] C_ZERO = 6'b010000, C_ADD = 6'b111100;
  logic [1:0]  state;
  logic [2:0]  op;
  logic [31:0] a, b, acc;
  logic [7:0]  cnt;
  logic [5:0]  op_code;
  logic        alu_op;
  assign alu_op    = op < 3'd6;
  assign cmd_ready = state == IDLE;
  assign res_valid = state == DONE;
  always_comb begin
    case (op)
      3'd0:    op_code = 6'b011000;
      3'd1:    op_code = 6'b111100;
      3'd2:    op_code = 6'b111111;
      3'd3:    op_code = 6'b001100;
      3'd4:    op_code = 6'b011100;
      3'd5:    op_code = 6'b111011;
      default: op_code = C_ZERO;
    endcase
  end
  // MUL with a zero count and the illegal op both pass through EXEC with the ALU idle
  always_comb begin
    ula_code = C_ZERO;
    ula_ah   = '0;
    ula_bb   = '0;
    if (state == EXEC && alu_op) begin
      ula_code = op_code;
      ula_ah   = a;
      ula_bb   = b;
    end else if (state == MUL) begin
      ula_code = C_ADD;
      ula_ah   = acc;
      ula_bb   = b;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op    <= cmd_op;
          a     <= cmd_a;
          b     <= cmd_b;
          acc   <= '0;
          cnt   <= cmd_a[7:0];
          state <= (cmd_op == 3'd6 && cmd_a[7:0] != 8'd0) ? MUL : EXEC;
        end
        EXEC: begin
          res_data <= alu_op ? ula_out : '0;
          res_err  <= op == 3'd7;
          state    <= DONE;
        end
        // ula_out already holds acc+B for this cycle, so the last sum is the product
        MUL: begin
          acc <= ula_out;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            res_data <= ula_out;
            res_err  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: if (res_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: randomized and directed checks of ula_seq against an arithmetic reference
module tb_ula_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [5:0]  ula_code;
  logic [31:0] ula_ah, ula_bb, ula_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  int          n_tests = 0, n_fail = 0;

  ula_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .ula_code(ula_code),
    .ula_ah(ula_ah), .ula_bb(ula_bb), .ula_out(ula_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // ALU stand-in: decodes the control words the block is allowed to use
  always_comb begin
    case (ula_code)
      6'b011000: ula_out = ula_ah;
      6'b111100: ula_out = ula_ah + ula_bb;
      6'b111111: ula_out = ula_bb - ula_ah;
      6'b001100: ula_out = ula_ah & ula_bb;
      6'b011100: ula_out = ula_ah | ula_bb;
      6'b111011: ula_out = -ula_ah;
      6'b010000: ula_out = '0;
      default:   ula_out = 32'hdeadbeef;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return b - a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return -a;
      3'd6:    return 32'(a[7:0]) * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [5:0] ref_code(input logic [2:0] op, input int n);
    logic [5:0] t [8] = '{6'b011000, 6'b111100, 6'b111111, 6'b001100,
                          6'b011100, 6'b111011, 6'b111100, 6'b010000};
    return (op == 3'd6 && n == 0) ? 6'b010000 : t[op];
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_d;
    int n, lat, exp_lat;
    n       = int'(a[7:0]);
    exp_d   = ref_result(op, a, b);
    exp_lat = op == 3'd6 ? (n == 0 ? 1 : n) + 1 : 2;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'($urandom);
    cmd_op    = 3'($urandom);
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    chk("exec_code", 32'(ula_code), 32'(ref_code(op, n)));
    if (op < 3'd6) begin
      chk("exec_ah", ula_ah, a);
      chk("exec_bb", ula_bb, b);
    end
    lat = 1;
    while (!res_valid && lat < 300) begin
      if (op == 3'd6 && n > 0) chk("mul_code", 32'(ula_code), 32'h3c);
      @(posedge clk); #1;
      lat++;
      cmd_valid = 1'($urandom);
      cmd_a     = $urandom;
    end
    chk("latency", lat, exp_lat);
    chk("res_data", res_data, exp_d);
    chk("res_err", 32'(res_err), 32'(op == 3'd7));
    chk("busy_ready", 32'(cmd_ready), 32'd0);
    chk("done_code", 32'(ula_code), 32'h10);
    repeat (hold) begin
      cmd_valid = 1'b1;
      cmd_a     = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", res_data, exp_d);
      chk("hold_err", 32'(res_err), 32'(op == 3'd7));
      chk("hold_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("retire_valid", 32'(res_valid), 32'd0);
    chk("retire_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_err"}, 32'(res_err), 32'd0);
    chk({tag, "_data"}, res_data, 32'd0);
    chk({tag, "_code"}, 32'(ula_code), 32'h10);
    chk({tag, "_ah"}, ula_ah, 32'd0);
    chk({tag, "_bb"}, ula_bb, 32'd0);
  endtask

  initial begin
    logic [31:0] x1, y1, x2, y2, a;
    logic [2:0]  op;
    int t0, t1, nr;
    #2;
    chk_reset_state("por");
    #1 rst_n = 1'b1;
    run_cmd(3'd1, 32'd5, 32'd7, 0);
    run_cmd(3'd2, 32'd3, 32'd1, 1);
    run_cmd(3'd5, 32'd1, 32'd0, 0);
    run_cmd(3'd6, 32'h105, 32'd3, 0);
    run_cmd(3'd6, 32'd0, 32'd9, 0);
    run_cmd(3'd7, $urandom, $urandom, 4);
    run_cmd(3'd1, 32'hffffffff, 32'd2, 0);
    // asynchronous reset in the middle of a long multiply
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_a = 32'd200; cmd_b = 32'd11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_state("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    run_cmd(3'd1, 32'd100, 32'd23, 0);
    // back-to-back ADDs with the consumer always ready
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    t0 = -1; t1 = -1; nr = 0;
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = x1; cmd_b = y1;
    for (int i = 0; i < 20 && nr < 2; i++) begin
      @(negedge clk);
      if (res_valid) begin
        chk(nr == 0 ? "b2b_first" : "b2b_second", res_data, nr == 0 ? x1 + y1 : x2 + y2);
        nr++;
      end
      if (cmd_ready && cmd_valid) begin
        if (t0 < 0) t0 = i;
        else t1 = i;
      end
      @(posedge clk); #1;
      if (t1 >= 0) cmd_valid = 1'b0;
      else if (t0 >= 0) begin cmd_a = x2; cmd_b = y2; end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk("b2b_count", nr, 2);
    chk("b2b_gap", t1 - t0, 3);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if (op == 3'd6 && $urandom_range(0, 3) == 0) a[7:0] = 8'd0;
      run_cmd(op, a, $urandom, $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
